// File: rtl/im2col_win_sched_if.sv
// Handshake bundle between the window scheduler, its frame controller and the im2col address stage.
// im2ColCmd packs {kerWidth[1:0], startAddrX[XW-1:0], startAddrY[YW-1:0], dv}, MSB first.
interface im2col_win_sched_if #(
  parameter int XW = 3,
  parameter int YW = 4
) ();
  logic                  start;
  logic [1:0]            kerWidth;
  logic [XW:0]           imgWidth;
  logic [YW:0]           imgHeight;
  logic [1:0]            stride;
  logic [XW+YW+2:0]      im2ColCmd;
  logic                  im2ColDone;
  logic                  winLast;
  logic                  busy;
  logic                  frameDone;
  logic                  cfgErr;

  modport master (
    output start, kerWidth, imgWidth, imgHeight, stride, im2ColDone,
    input  im2ColCmd, winLast, busy, frameDone, cfgErr
  );

  modport slave (
    input  start, kerWidth, imgWidth, imgHeight, stride, im2ColDone,
    output im2ColCmd, winLast, busy, frameDone, cfgErr
  );
endinterface

// File: rtl/im2col_win_sched.sv
// Walks a KxK window over the image with the given stride and issues one im2col
// command per kernel row, waiting for the address stage to finish each one.
module im2col_win_sched #(
  parameter int cMaxKerWidth = 4,
  parameter int cNumOfRam    = 8,
  parameter int cRamDepth    = 16
) (
  input logic               clk,
  input logic               rst,
  im2col_win_sched_if.slave bus
);
  localparam int XW = (cNumOfRam > 2) ? $clog2(cNumOfRam - 1) : 1;
  localparam int YW = (cRamDepth > 2) ? $clog2(cRamDepth - 1) : 1;
  localparam int XE = XW + 2;
  localparam int YE = YW + 2;
  localparam int RW = (cMaxKerWidth > 2) ? $clog2(cMaxKerWidth) : 1;
  localparam int CW = XW + YW + 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t          state;
  logic [1:0]      kw_q;
  logic [XW:0]     w_q;
  logic [YW:0]     h_q;
  logic [1:0]      s_q;
  logic [XW-1:0]   win_x;
  logic [YW-1:0]   win_y;
  logic [RW-1:0]   k_row;

  logic [CW-1:0]   cmd_q;
  logic            win_last_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            cfg_err_q;

  logic [XE-1:0]   x_end;
  logic [YE-1:0]   y_end;
  logic            row_last, x_wrap, y_wrap, frame_last;
  logic            cfg_bad;
  logic [1:0]      s_in;
  logic [XW-1:0]   nxt_x;
  logic [YW-1:0]   nxt_y;
  logic [RW-1:0]   nxt_row;

  // Bounds use two extra bits so winX+stride+K never wraps before the compare.
  always_comb begin
    x_end      = XE'(win_x) + XE'(s_q) + XE'(kw_q) + XE'(1);
    y_end      = YE'(win_y) + YE'(s_q) + YE'(kw_q) + YE'(1);
    row_last   = (k_row == RW'(kw_q));
    x_wrap     = (x_end > XE'(w_q));
    y_wrap     = (y_end > YE'(h_q));
    frame_last = row_last && x_wrap && y_wrap;
    cfg_bad    = ((XE'(bus.kerWidth) + XE'(1)) > XE'(bus.imgWidth)) ||
                 ((YE'(bus.kerWidth) + YE'(1)) > YE'(bus.imgHeight));
    s_in       = (bus.stride == 2'd0) ? 2'd1 : bus.stride;

    nxt_x   = win_x;
    nxt_y   = win_y;
    nxt_row = k_row + RW'(1);
    if (row_last) begin
      nxt_row = '0;
      if (x_wrap) begin
        nxt_x = '0;
        nxt_y = win_y + YW'(s_q);
      end else begin
        nxt_x = win_x + XW'(s_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      kw_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      s_q          <= '0;
      win_x        <= '0;
      win_y        <= '0;
      k_row        <= '0;
      cmd_q        <= '0;
      win_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cmd_q        <= '0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            kw_q  <= bus.kerWidth;
            w_q   <= bus.imgWidth;
            h_q   <= bus.imgHeight;
            s_q   <= s_in;
            win_x <= '0;
            win_y <= '0;
            k_row <= '0;
            if (cfg_bad) begin
              state        <= FIN;
              frame_done_q <= 1'b1;
              cfg_err_q    <= 1'b1;
            end else begin
              state      <= ISSUE;
              busy_q     <= 1'b1;
              cfg_err_q  <= 1'b0;
              cmd_q      <= {bus.kerWidth, {XW{1'b0}}, {YW{1'b0}}, 1'b1};
              win_last_q <= (bus.kerWidth == 2'd0);
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.im2ColDone) begin
            if (frame_last) begin
              state        <= FIN;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              state      <= ISSUE;
              win_x      <= nxt_x;
              win_y      <= nxt_y;
              k_row      <= nxt_row;
              cmd_q      <= {kw_q, nxt_x, YW'(nxt_y + YW'(nxt_row)), 1'b1};
              win_last_q <= (nxt_row == RW'(kw_q));
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.im2ColCmd = cmd_q;
  assign bus.winLast   = win_last_q;
  assign bus.busy      = busy_q;
  assign bus.frameDone = frame_done_q;
  assign bus.cfgErr    = cfg_err_q;
endmodule

// File: tb/tb_im2col_win_sched.sv
// Scoreboard bench: a window-walk reference queues every expected command and frame
// end; a monitor pops and compares whenever the scheduler presents an output.
module tb_im2col_win_sched;
  localparam int XW = 3;
  localparam int YW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  im2col_win_sched_if #(.XW(XW), .YW(YW)) bus ();

  im2col_win_sched #(.cMaxKerWidth(4), .cNumOfRam(8), .cRamDepth(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit is_done;
    int x;
    int y;
    int kw;
    bit last;
    bit err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   dv_count = 0;
  bit   resp_en = 1'b0;
  bit   inj_en = 1'b0;
  int   fix_delay = 0;

  logic          dv;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [1:0]    ckw;
  assign dv  = bus.im2ColCmd[0];
  assign cy  = bus.im2ColCmd[YW:1];
  assign cx  = bus.im2ColCmd[XW+YW:YW+1];
  assign ckw = bus.im2ColCmd[XW+YW+2:XW+YW+1];

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: every valid KxK window, scanned row-major, one command per kernel row.
  task automatic push_frame(input int kw, input int w, input int h, input int s, output int n);
    exp_t e;
    int k, st;
    k  = kw + 1;
    st = (s == 0) ? 1 : s;
    n  = 0;
    if (k > w || k > h) begin
      e = '{is_done: 1'b1, x: 0, y: 0, kw: 0, last: 1'b0, err: 1'b1};
      sbq.push_back(e);
      return;
    end
    for (int y = 0; y + k <= h; y += st)
      for (int x = 0; x + k <= w; x += st)
        for (int r = 0; r < k; r++) begin
          e = '{is_done: 1'b0, x: x, y: y + r, kw: kw, last: (r == k - 1), err: 1'b0};
          sbq.push_back(e);
          n++;
        end
    e = '{is_done: 1'b1, x: 0, y: 0, kw: 0, last: 1'b0, err: 1'b0};
    sbq.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (dv || bus.frameDone)) begin
        check("dv_fd_exclusive", int'(dv & bus.frameDone), 0);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output dv=%0d frameDone=%0d", dv, bus.frameDone);
        end else begin
          e = sbq.pop_front();
          if (dv) begin
            dv_count++;
            check("cmd_kind", int'(e.is_done), 0);
            check("cmd_x", int'(cx), e.x);
            check("cmd_y", int'(cy), e.y);
            check("cmd_kw", int'(ckw), e.kw);
            check("cmd_winlast", int'(bus.winLast), int'(e.last));
            check("cmd_busy", int'(bus.busy), 1);
          end else begin
            check("fd_kind", int'(e.is_done), 1);
            check("fd_cfgerr", int'(bus.cfgErr), int'(e.err));
            check("fd_busy", int'(bus.busy), 0);
          end
        end
      end else if (!rst) begin
        check("idle_winlast", int'(bus.winLast), 0);
      end
    end
  end

  // Address-stage responder, optionally also pulsing done during the issue cycle.
  initial begin
    int d;
    bus.im2ColDone = 1'b0;
    forever begin
      @(negedge clk);
      bus.im2ColDone = 1'b0;
      while (resp_en && dv) begin
        if (inj_en && $urandom_range(0, 1) == 1) bus.im2ColDone = 1'b1;
        d = (fix_delay != 0) ? fix_delay : $urandom_range(1, 3);
        repeat (d) begin
          @(negedge clk);
          bus.im2ColDone = 1'b0;
        end
        if (!resp_en) break;
        bus.im2ColDone = 1'b1;
        @(negedge clk);
        bus.im2ColDone = 1'b0;
        check("done_latency", int'(dv | bus.frameDone), 1);
      end
    end
  end

  task automatic drive_cfg(input int kw, input int w, input int h, input int s);
    bus.kerWidth  = 2'(kw);
    bus.imgWidth  = (XW+1)'(w);
    bus.imgHeight = (YW+1)'(h);
    bus.stride    = 2'(s);
  endtask

  task automatic run_frame(input int kw, input int w, input int h, input int s, input bit inj);
    int n, cyc;
    bit rej;
    rej = (kw + 1 > w) || (kw + 1 > h);
    push_frame(kw, w, h, s, n);
    dv_count = 0;
    inj_en   = inj;
    @(negedge clk);
    drive_cfg(kw, w, h, s);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_latency", int'({dv, bus.frameDone, bus.busy}), rej ? 3'b010 : 3'b101);
    cyc = 0;
    while (!bus.frameDone && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (inj && bus.busy && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1;
        drive_cfg($urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(1, 16), $urandom_range(0, 3));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!bus.frameDone) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout cycles=%0d required_frameDone=1", cyc);
      sbq.delete();
    end
    check("cmd_count", dv_count, n);
    @(negedge clk);
    check("fd_single_pulse", int'(bus.frameDone), 0);
    check("busy_after_frame", int'(bus.busy), 0);
    inj_en = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    drive_cfg(0, 1, 1, 0);
    repeat (2) @(negedge clk);
    check("reset_cmd", int'(bus.im2ColCmd), 0);
    check("reset_flags", int'({bus.winLast, bus.busy, bus.frameDone, bus.cfgErr}), 0);
    rst = 1'b0;
    resp_en = 1'b1;

    // 3x3 over 5x4, stride 1, done two cycles after each command
    fix_delay = 2;
    run_frame(2, 5, 4, 1, 1'b0);
    fix_delay = 0;
    // 2x2 over 6x2, stride 2
    run_frame(1, 6, 2, 2, 1'b0);
    check("cfgerr_clear_ok", int'(bus.cfgErr), 0);
    // kernel wider than image
    run_frame(3, 3, 8, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("cfgerr_held", int'(bus.cfgErr), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_clears_cfgerr", int'(bus.cfgErr), 0);
    rst = 1'b0;
    // Disturbed run: extra starts mid-frame and done pulses during issue cycles
    run_frame(2, 5, 4, 1, 1'b1);

    // Reset while waiting for the address stage
    resp_en = 1'b0;
    push_frame(2, 5, 4, 1, n);
    @(negedge clk);
    drive_cfg(2, 5, 4, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait_cmd", int'(bus.im2ColCmd), 0);
    check("rstwait_flags", int'({bus.winLast, bus.busy, bus.frameDone, bus.cfgErr}), 0);
    rst = 1'b0;
    sbq.delete();
    repeat (4) @(negedge clk);
    check("rstwait_no_fd", int'(bus.frameDone), 0);
    resp_en = 1'b1;
    run_frame(2, 5, 4, 1, 1'b0);

    for (int i = 0; i < 25; i++)
      run_frame($urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(1, 16),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/im2col_win_sched.md
IM2COL_WIN_SCHED -- requirements
Module: im2col_win_sched

Interface
REQ-001 Parameter cMaxKerWidth, default 4, maximum kernel width and height in pixels; from im2ColPckg.
REQ-002 Parameter cNumOfRam, default from ramPckg, number of column RAMs; derived XW = log2(cNumOfRam-1).
REQ-003 Parameter cRamDepth, default from ramPckg, RAM depth in rows; derived YW = log2(cRamDepth-1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle frame start pulse; configuration is sampled with it.
REQ-007 kerWidth  in  2  kernel size minus 1 (K = kerWidth+1, range 1..4).
REQ-008 imgWidth  in  XW+1  image width in columns (range 1..cNumOfRam).
REQ-009 imgHeight  in  YW+1  image height in rows (range 1..cRamDepth).
REQ-010 stride  in  2  window step in x and y; 0 is treated as 1.
REQ-011 im2ColCmd  out  tIm2ColIn  {kerWidth, startAddrX, startAddrY, dv} command to the im2col address stage.
REQ-012 im2ColDone  in  1  done from the im2col address stage for the current command.
REQ-013 winLast  out  1  high with im2ColCmd.dv on the last kernel row of a window.
REQ-014 busy  out  1  high from the cycle after an accepted start until frameDone.
REQ-015 frameDone  out  1  one-cycle pulse when the frame finishes or is rejected.
REQ-016 cfgErr  out  1  high with frameDone when the configuration is rejected; held until the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and FIN.
REQ-018 In IDLE, start SHALL latch the configuration, clear the counters winX, winY and kRow, and go to ISSUE; if K > imgWidth or K > imgHeight, it SHALL go to FIN with cfgErr set instead.
REQ-019 ISSUE SHALL last exactly one cycle with im2ColCmd.dv=1, startAddrX=winX, startAddrY=winY+kRow and kerWidth=latched value, then go to WAIT.
REQ-020 winLast SHALL equal (kRow == K-1) during ISSUE and 0 otherwise.
REQ-021 WAIT SHALL hold all outputs except busy at 0; on im2ColDone the counters SHALL advance and the FSM SHALL go to ISSUE on the next cycle, or to FIN after the last command.
REQ-022 Advance order: kRow++; at kRow==K-1, kRow=0 and winX += stride; if winX+stride+K > imgWidth, winX=0 and winY += stride; if winY+stride+K > imgHeight, the frame is complete.
REQ-023 Bound comparisons SHALL be computed at XW+2 / YW+2 bits so they cannot overflow.
REQ-024 FIN SHALL last one cycle: frameDone=1, busy=0 in that cycle, then go to IDLE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 im2ColDone SHALL be ignored outside WAIT, including when it arrives in the same cycle as ISSUE.
REQ-027 Latency: start at cycle t gives the first dv at t+1; im2ColDone at cycle n gives the next dv, or frameDone, at n+1.
REQ-028 Total commands per frame SHALL be floor((W-K)/S+1) * floor((H-K)/S+1) * K.

Reset
REQ-029 rst SHALL force IDLE and clear the counters, latched configuration, im2ColCmd (all fields 0), winLast, busy, frameDone and cfgErr in the next cycle.
REQ-030 rst SHALL take priority over start and im2ColDone; a frame in progress SHALL be abandoned with no frameDone.

Verification
REQ-031 kerWidth=2, W=5, H=4, S=1, im2ColDone returned 2 cycles after each dv -> 18 commands; the first three are (x,y) = (0,0),(0,1),(0,2) with winLast on the third; the last is (2,3); then exactly one frameDone.
REQ-032 kerWidth=1, W=6, H=2, S=2 -> startAddrX sequence 0,0,2,2,4,4; startAddrY alternating 0,1; 6 commands; cfgErr=0.
REQ-033 kerWidth=3, W=3, H=8 -> no dv; frameDone and cfgErr at t+1; busy stays 0.
REQ-034 A second start mid-frame, plus im2ColDone pulses injected in ISSUE cycles -> command sequence identical to the undisturbed run.
REQ-035 rst asserted while in WAIT -> all outputs 0 next cycle; a new start then begins at (0,0) with kRow=0.
